huge_page_scheduler: RTL and testbench

- Sequences the four host huge pages that the host driver hands to hardware, one at a time, in strict ring order 1→2→3→4→1. The matching huge_page_addr_k/huge_page_status_k pairs come from the RX huge-page address capture.
- Hands out destination addresses chunk by chunk to the TX DMA writer and tracks the fill offset inside the current page.
- When the current page is full or flushed, waits until all outstanding writes have completed, then returns the page to the host with a one-cycle huge_page_free_k pulse.

---
 rtl/huge_page_scheduler_pkg.sv | 28 ++
 rtl/huge_page_scheduler_if.sv | 54 +++++
 rtl/huge_page_outstanding_ctr.sv | 64 ++++++
 rtl/huge_page_scheduler.sv | 160 ++++++++++++++++
 tb/tb_huge_page_scheduler.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/huge_page_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// huge_page_scheduler_pkg
//   Shared definitions for the huge page scheduler slice.
//   - Default parameter values (page size, outstanding limit, chunk width)
//   - Number of host huge pages in the ring
//   - One-hot FSM state encoding
//   - next_page(): ring increment of the page index
// -----------------------------------------------------------------------------
package huge_page_scheduler_pkg;

  localparam int PAGE_SIZE_LOG2_DEF  = 21;
  localparam int MAX_OUTSTANDING_DEF = 8;
  localparam int CHUNK_W_DEF         = 10;
  localparam int NUM_HUGE_PAGES      = 4;

  typedef enum logic [3:0] {
    WAIT_PAGE = 4'b0001,
    ACTIVE    = 4'b0010,
    DRAIN     = 4'b0100,
    RELEASE   = 4'b1000
  } sched_state_e;

  // Ring order 0->1->2->3->0; the 2-bit add wraps naturally.
  function automatic logic [1:0] next_page(input logic [1:0] page);
    return page + 2'd1;
  endfunction

endpackage

// File: rtl/huge_page_scheduler_if.sv
// -----------------------------------------------------------------------------
// huge_page_scheduler_if
//   Bundles the host page hand-off signals and the TX DMA writer chunk
//   handshake.
//   master : host driver + DMA writer side (drives page addr/status,
//            chunk_req/chunk_qwords/chunk_done/page_flush)
//   slave  : scheduler side (drives free pulses, chunk_gnt/chunk_addr,
//            cur_page, err_underflow)
// -----------------------------------------------------------------------------
interface huge_page_scheduler_if
  import huge_page_scheduler_pkg::*;
#(
  parameter int CHUNK_W = CHUNK_W_DEF
);

  logic [63:0]        huge_page_addr_1;
  logic [63:0]        huge_page_addr_2;
  logic [63:0]        huge_page_addr_3;
  logic [63:0]        huge_page_addr_4;
  logic               huge_page_status_1;
  logic               huge_page_status_2;
  logic               huge_page_status_3;
  logic               huge_page_status_4;
  logic               huge_page_free_1;
  logic               huge_page_free_2;
  logic               huge_page_free_3;
  logic               huge_page_free_4;

  logic               chunk_req;
  logic [CHUNK_W-1:0] chunk_qwords;
  logic               chunk_gnt;
  logic [63:0]        chunk_addr;
  logic               chunk_done;
  logic               page_flush;
  logic [1:0]         cur_page;
  logic               err_underflow;

  modport master (
    output huge_page_addr_1, huge_page_addr_2, huge_page_addr_3, huge_page_addr_4,
    output huge_page_status_1, huge_page_status_2, huge_page_status_3, huge_page_status_4,
    input  huge_page_free_1, huge_page_free_2, huge_page_free_3, huge_page_free_4,
    output chunk_req, chunk_qwords, chunk_done, page_flush,
    input  chunk_gnt, chunk_addr, cur_page, err_underflow
  );

  modport slave (
    input  huge_page_addr_1, huge_page_addr_2, huge_page_addr_3, huge_page_addr_4,
    input  huge_page_status_1, huge_page_status_2, huge_page_status_3, huge_page_status_4,
    output huge_page_free_1, huge_page_free_2, huge_page_free_3, huge_page_free_4,
    input  chunk_req, chunk_qwords, chunk_done, page_flush,
    output chunk_gnt, chunk_addr, cur_page, err_underflow
  );

endinterface

// File: rtl/huge_page_outstanding_ctr.sv
// -----------------------------------------------------------------------------
// huge_page_outstanding_ctr
//   Counts granted chunks whose writes have not yet completed.
//   Ports:
//     trn_clk, reset : clock, synchronous active-high reset
//     inc_i          : a chunk was granted this cycle
//     dec_i          : a chunk write completed this cycle
//     count_o        : current outstanding count
//     full_o         : count == MAX_COUNT
//     underflow_o    : sticky, set when dec_i arrives with count == 0
// -----------------------------------------------------------------------------
module huge_page_outstanding_ctr
  import huge_page_scheduler_pkg::*;
#(
  parameter  int MAX_COUNT = MAX_OUTSTANDING_DEF,
  localparam int CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic             trn_clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             underflow_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_COUNT);

  logic [CNT_W-1:0] count_q, count_d;
  logic             underflow_q, underflow_d;

  always_comb begin
    count_d     = count_q;
    underflow_d = underflow_q;
    if (dec_i && (count_q == '0)) begin
      // A completion with nothing outstanding is dropped; the counter holds
      // at zero, but a grant in the same cycle still counts.
      underflow_d = 1'b1;
      if (inc_i) begin
        count_d = ONE;
      end
    end else if (inc_i && !dec_i && (count_q != MAX)) begin
      count_d = count_q + ONE;
    end else if (dec_i && !inc_i) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  assign count_o     = count_q;
  assign full_o      = (count_q == MAX);
  assign underflow_o = underflow_q;

endmodule

// File: rtl/huge_page_scheduler.sv
// -----------------------------------------------------------------------------
// huge_page_scheduler
//   Walks the four host huge pages in strict ring order, hands out chunk
//   destination addresses to the TX DMA writer, and returns each page to the
//   host with a one-cycle free pulse once it is full/flushed and drained.
//   Ports:
//     trn_clk : system clock
//     reset   : synchronous, active-high reset
//     bus     : huge_page_scheduler_if.slave (page hand-off + chunk handshake)
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   WAIT_PAGE | waiting for the host to hand page cur_page to hardware
//   ACTIVE    | granting chunks from the current page
//   DRAIN     | page closed; waiting for all outstanding writes to finish
//   RELEASE   | one cycle: pulse free for cur_page, then advance the ring
// -----------------------------------------------------------------------------
module huge_page_scheduler
  import huge_page_scheduler_pkg::*;
#(
  parameter int PAGE_SIZE_LOG2  = PAGE_SIZE_LOG2_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int CHUNK_W         = CHUNK_W_DEF
) (
  input logic                  trn_clk,
  input logic                  reset,
  huge_page_scheduler_if.slave bus
);

  localparam int OFF_W = PAGE_SIZE_LOG2 + 1;
  // One extra bit so offset + chunk can never wrap before the fit compare.
  localparam int SUM_W = OFF_W + 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [OFF_W-1:0] PAGE_BYTES_O = OFF_W'(1) << PAGE_SIZE_LOG2;
  localparam logic [SUM_W-1:0] PAGE_BYTES_S = SUM_W'(1) << PAGE_SIZE_LOG2;

  sched_state_e      state_q, state_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [1:0]        cur_page_q, cur_page_d;
  logic              chunk_gnt_q, chunk_gnt_d;
  logic [63:0]       chunk_addr_q, chunk_addr_d;

  logic [63:0]               page_addr [NUM_HUGE_PAGES];
  logic [NUM_HUGE_PAGES-1:0] page_status;

  logic [SUM_W-1:0]  chunk_bytes;
  logic [SUM_W-1:0]  offset_next;
  logic              chunk_fits;
  logic              page_full;
  logic              grant;

  logic [CNT_W-1:0]  outstanding;
  logic              ctr_full;
  logic              ctr_underflow;
  logic              ctr_room;

  assign page_addr[0] = bus.huge_page_addr_1;
  assign page_addr[1] = bus.huge_page_addr_2;
  assign page_addr[2] = bus.huge_page_addr_3;
  assign page_addr[3] = bus.huge_page_addr_4;
  assign page_status  = {bus.huge_page_status_4, bus.huge_page_status_3,
                         bus.huge_page_status_2, bus.huge_page_status_1};

  assign chunk_bytes = SUM_W'({bus.chunk_qwords, 3'b000});
  assign offset_next = SUM_W'(offset_q) + chunk_bytes;
  assign chunk_fits  = (offset_next <= PAGE_BYTES_S);
  assign page_full   = (offset_q == PAGE_BYTES_O);
  // A completion arriving in the same cycle frees a slot for this grant.
  assign ctr_room    = !ctr_full || bus.chunk_done;

  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    cur_page_d   = cur_page_q;
    chunk_gnt_d  = 1'b0;
    chunk_addr_d = chunk_addr_q;
    grant        = 1'b0;
    unique case (state_q)
      WAIT_PAGE: begin
        if (page_status[cur_page_q]) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (bus.page_flush && (offset_q != '0)) begin
          state_d = DRAIN;
        end else if (page_full) begin
          state_d = DRAIN;
        end else if (bus.chunk_req && !chunk_gnt_q) begin
          // During the grant cycle the writer may still hold the request it
          // was just granted; gating on chunk_gnt_q keeps that stale request
          // from being judged a misfit against the already-advanced offset.
          if (!chunk_fits) begin
            state_d = DRAIN;
          end else if (ctr_room) begin
            grant        = 1'b1;
            chunk_gnt_d  = 1'b1;
            chunk_addr_d = page_addr[cur_page_q] + 64'(offset_q);
            offset_d     = offset_next[OFF_W-1:0];
          end
        end
      end
      DRAIN: begin
        if (outstanding == '0) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        state_d    = WAIT_PAGE;
        cur_page_d = next_page(cur_page_q);
        offset_d   = '0;
      end
      default: begin
        state_d = WAIT_PAGE;
      end
    endcase
  end

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      state_q      <= WAIT_PAGE;
      offset_q     <= '0;
      cur_page_q   <= 2'd0;
      chunk_gnt_q  <= 1'b0;
      chunk_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      cur_page_q   <= cur_page_d;
      chunk_gnt_q  <= chunk_gnt_d;
      chunk_addr_q <= chunk_addr_d;
    end
  end

  huge_page_outstanding_ctr #(
    .MAX_COUNT (MAX_OUTSTANDING)
  ) u_outstanding_ctr (
    .trn_clk     (trn_clk),
    .reset       (reset),
    .inc_i       (grant),
    .dec_i       (bus.chunk_done),
    .count_o     (outstanding),
    .full_o      (ctr_full),
    .underflow_o (ctr_underflow)
  );

  assign bus.chunk_gnt     = chunk_gnt_q;
  assign bus.chunk_addr    = chunk_addr_q;
  assign bus.cur_page      = cur_page_q;
  assign bus.err_underflow = ctr_underflow;

  // Free pulses are decoded from registered state, so each is exactly the
  // single RELEASE cycle wide.
  assign bus.huge_page_free_1 = (state_q == RELEASE) && (cur_page_q == 2'd0);
  assign bus.huge_page_free_2 = (state_q == RELEASE) && (cur_page_q == 2'd1);
  assign bus.huge_page_free_3 = (state_q == RELEASE) && (cur_page_q == 2'd2);
  assign bus.huge_page_free_4 = (state_q == RELEASE) && (cur_page_q == 2'd3);

endmodule

// File: tb/tb_huge_page_scheduler.sv
`timescale 1ns/1ps
module tb_huge_page_scheduler;
  import huge_page_scheduler_pkg::*;

  localparam int PAGE_BYTES = 1 << 21;
  localparam int MAX_OUT    = 8;

  logic trn_clk = 1'b0;
  logic reset;

  always #5 trn_clk = ~trn_clk;

  huge_page_scheduler_if #(.CHUNK_W(10)) bus();

  huge_page_scheduler #(
    .PAGE_SIZE_LOG2  (21),
    .MAX_OUTSTANDING (MAX_OUT),
    .CHUNK_W         (10)
  ) dut (
    .trn_clk (trn_clk),
    .reset   (reset),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int free_cnt [4];

  // Counts cycles each free output is high; a correct pulse adds exactly 1.
  always @(posedge trn_clk) begin
    if (bus.huge_page_free_1 === 1'b1) free_cnt[0]++;
    if (bus.huge_page_free_2 === 1'b1) free_cnt[1]++;
    if (bus.huge_page_free_3 === 1'b1) free_cnt[2]++;
    if (bus.huge_page_free_4 === 1'b1) free_cnt[3]++;
  end

  task automatic tick();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic set_status(input logic [3:0] s);
    bus.huge_page_status_1 = s[0];
    bus.huge_page_status_2 = s[1];
    bus.huge_page_status_3 = s[2];
    bus.huge_page_status_4 = s[3];
  endtask

  task automatic set_addrs(input logic [63:0] a0, input logic [63:0] a1,
                           input logic [63:0] a2, input logic [63:0] a3);
    bus.huge_page_addr_1 = a0;
    bus.huge_page_addr_2 = a1;
    bus.huge_page_addr_3 = a2;
    bus.huge_page_addr_4 = a3;
  endtask

  task automatic apply_reset();
    reset            = 1'b1;
    bus.chunk_req    = 1'b0;
    bus.chunk_qwords = '0;
    bus.chunk_done   = 1'b0;
    bus.page_flush   = 1'b0;
    set_status(4'b0000);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_done();
    bus.chunk_done = 1'b1;
    tick();
    bus.chunk_done = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.page_flush = 1'b1;
    tick();
    bus.page_flush = 1'b0;
  endtask

  // Writer model: raise request, wait (bounded) for grant, keep the request
  // up through the grant cycle, then drop it. Reports what was observed.
  task automatic request_chunk(input int qw, input int budget, output bit got,
                               output logic [63:0] addr, output int lat,
                               output bit dbl);
    got = 1'b0; addr = '0; lat = 0; dbl = 1'b0;
    bus.chunk_qwords = qw[9:0];
    bus.chunk_req    = 1'b1;
    while (!got && lat < budget) begin
      tick();
      lat++;
      if (bus.chunk_gnt === 1'b1) begin
        got  = 1'b1;
        addr = bus.chunk_addr;
      end
    end
    if (got) begin
      tick();
      dbl = (bus.chunk_gnt === 1'b1);
    end
    bus.chunk_req = 1'b0;
  endtask

  task automatic wait_free(input int k, input int base, input int budget,
                           output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      tick();
      if (free_cnt[k] > base) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit got, dbl; logic [63:0] a; int lat;
    apply_reset();
    n_checks++; if (bus.chunk_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0", bus.chunk_gnt); end
    n_checks++; if (bus.chunk_addr !== 64'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", bus.chunk_addr); end
    n_checks++; if (bus.cur_page !== 2'd0) begin n_fail++; $display("FAIL reset_cur_page: got %0d expected 0", bus.cur_page); end
    n_checks++; if (bus.err_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err_underflow); end
    n_checks++;
    if ({bus.huge_page_free_4, bus.huge_page_free_3, bus.huge_page_free_2, bus.huge_page_free_1} !== 4'b0) begin
      n_fail++; $display("FAIL reset_free: got %b%b%b%b expected 0000", bus.huge_page_free_4,
                         bus.huge_page_free_3, bus.huge_page_free_2, bus.huge_page_free_1);
    end
    request_chunk(16, 6, got, a, lat, dbl);
    n_checks++; if (got !== 1'b0) begin n_fail++; $display("FAIL wait_page_no_grant: got grant=%b expected 0", got); end
  endtask

  task automatic test_basic_grant();
    bit got, dbl; logic [63:0] a; int lat;
    apply_reset();
    set_addrs(64'h0000_0001_0000_0000, 64'h0000_0002_0000_0000, 64'h0, 64'h0);
    set_status(4'b0001);
    tick(); tick();
    request_chunk(16, 10, got, a, lat, dbl);
    n_checks++; if (got !== 1'b1 || lat !== 1) begin n_fail++; $display("FAIL basic_lat1: got grant=%b lat=%0d expected grant=1 lat=1", got, lat); end
    n_checks++; if (a !== 64'h0000_0001_0000_0000) begin n_fail++; $display("FAIL basic_addr1: got %h expected 100000000", a); end
    n_checks++; if (dbl !== 1'b0) begin n_fail++; $display("FAIL basic_gap: got back-to-back gnt=%b expected 0", dbl); end
    request_chunk(16, 10, got, a, lat, dbl);
    n_checks++; if (got !== 1'b1 || lat !== 1) begin n_fail++; $display("FAIL basic_lat2: got grant=%b lat=%0d expected grant=1 lat=1", got, lat); end
    n_checks++; if (a !== 64'h0000_0001_0000_0080) begin n_fail++; $display("FAIL basic_addr2: got %h expected 100000080", a); end
    pulse_done(); pulse_done();
  endtask

  task automatic test_page_fill();
    bit got, dbl, seen; logic [63:0] a, first_bad; int lat, bad, f0, f1;
    apply_reset();
    set_addrs(64'h0000_0001_0000_0000, 64'h0000_0002_0000_0000, 64'h0, 64'h0);
    set_status(4'b0011);
    f0 = free_cnt[0]; f1 = free_cnt[1];
    bad = 0; first_bad = '0;
    for (int i = 0; i < 4096; i++) begin
      request_chunk(64, 10, got, a, lat, dbl);
      if (!got || a !== 64'h0000_0001_0000_0000 + 64'(i) * 64'd512) begin
        if (bad == 0) first_bad = a;
        bad++;
      end
      if (i != 4095) pulse_done();
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL fill_addrs: got %0d bad grants (first %h) expected 0", bad, first_bad); end
    repeat (5) tick();
    n_checks++; if (free_cnt[0] - f0 !== 0) begin n_fail++; $display("FAIL fill_early_free: got %0d pulses expected 0", free_cnt[0] - f0); end
    pulse_done();
    wait_free(0, f0, 10, seen);
    tick(); tick();
    n_checks++; if (free_cnt[0] - f0 !== 1) begin n_fail++; $display("FAIL fill_free1: got %0d cycles expected 1", free_cnt[0] - f0); end
    n_checks++; if (bus.cur_page !== 2'd1) begin n_fail++; $display("FAIL fill_cur_page: got %0d expected 1", bus.cur_page); end
    request_chunk(64, 10, got, a, lat, dbl);
    n_checks++; if (got !== 1'b1 || a !== 64'h0000_0002_0000_0000) begin n_fail++; $display("FAIL fill_next_page: got grant=%b addr=%h expected 200000000", got, a); end
    n_checks++; if (free_cnt[1] - f1 !== 0) begin n_fail++; $display("FAIL fill_free2: got %0d expected 0", free_cnt[1] - f1); end
    pulse_done();
  endtask

  task automatic test_misfit();
    bit got, dbl; logic [63:0] a; int lat, bad, gseen, f0;
    apply_reset();
    set_addrs(64'h0000_0001_0000_0000, 64'h0000_0002_0000_0000, 64'h0, 64'h0);
    set_status(4'b0011);
    f0 = free_cnt[0];
    bad = 0;
    for (int i = 0; i < 511; i++) begin
      request_chunk(512, 10, got, a, lat, dbl);
      if (!got || a !== 64'h0000_0001_0000_0000 + 64'(i) * 64'd4096) bad++;
      pulse_done();
    end
    request_chunk(480, 10, got, a, lat, dbl);
    if (!got || a !== 64'h0000_0001_001F_F000) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL misfit_fill: got %0d bad grants expected 0", bad); end
    // Offset now 0x1FFF00 with one write outstanding; 512 B cannot fit.
    bus.chunk_qwords = 10'd64;
    bus.chunk_req    = 1'b1;
    gseen = 0;
    repeat (6) begin tick(); if (bus.chunk_gnt === 1'b1) gseen++; end
    n_checks++; if (gseen !== 0) begin n_fail++; $display("FAIL misfit_no_grant: got %0d grants expected 0", gseen); end
    n_checks++; if (free_cnt[0] - f0 !== 0) begin n_fail++; $display("FAIL misfit_early_free: got %0d expected 0", free_cnt[0] - f0); end
    pulse_done();
    got = 1'b0; a = '0;
    for (int c = 0; c < 12 && !got; c++) begin
      tick();
      if (bus.chunk_gnt === 1'b1) begin got = 1'b1; a = bus.chunk_addr; end
    end
    tick();
    bus.chunk_req = 1'b0;
    n_checks++; if (got !== 1'b1 || a !== 64'h0000_0002_0000_0000) begin n_fail++; $display("FAIL misfit_next_base: got grant=%b addr=%h expected 200000000", got, a); end
    n_checks++; if (free_cnt[0] - f0 !== 1) begin n_fail++; $display("FAIL misfit_free1: got %0d expected 1", free_cnt[0] - f0); end
    pulse_done();
  endtask

  task automatic test_outstanding_limit();
    bit got, dbl; logic [63:0] a; int lat, bad, gseen;
    apply_reset();
    set_addrs(64'h0000_0005_0000_0000, 64'h0, 64'h0, 64'h0);
    set_status(4'b0001);
    bad = 0;
    for (int i = 0; i < MAX_OUT; i++) begin
      request_chunk(16, 10, got, a, lat, dbl);
      if (!got || a !== 64'h0000_0005_0000_0000 + 64'(i) * 64'd128) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL limit_fill: got %0d bad grants expected 0", bad); end
    bus.chunk_qwords = 10'd16;
    bus.chunk_req    = 1'b1;
    gseen = 0;
    repeat (4) begin tick(); if (bus.chunk_gnt === 1'b1) gseen++; end
    n_checks++; if (gseen !== 0) begin n_fail++; $display("FAIL limit_stall: got %0d grants expected 0", gseen); end
    bus.chunk_done = 1'b1;
    tick();
    bus.chunk_done = 1'b0;
    n_checks++; if (bus.chunk_gnt !== 1'b1 || bus.chunk_addr !== 64'h0000_0005_0000_0400) begin
      n_fail++; $display("FAIL limit_done_grant: got gnt=%b addr=%h expected gnt=1 addr=500000400", bus.chunk_gnt, bus.chunk_addr);
    end
    gseen = 0;
    repeat (4) begin tick(); if (bus.chunk_gnt === 1'b1) gseen++; end
    bus.chunk_req = 1'b0;
    n_checks++; if (gseen !== 0) begin n_fail++; $display("FAIL limit_still_full: got %0d grants expected 0", gseen); end
    repeat (MAX_OUT) pulse_done();
    n_checks++; if (bus.err_underflow !== 1'b0) begin n_fail++; $display("FAIL limit_no_underflow: got %b expected 0", bus.err_underflow); end
    request_chunk(16, 10, got, a, lat, dbl);
    n_checks++; if (got !== 1'b1 || lat !== 1 || a !== 64'h0000_0005_0000_0480) begin
      n_fail++; $display("FAIL limit_after_drain: got grant=%b lat=%0d addr=%h expected 1/1/500000480", got, lat, a);
    end
    pulse_done();
  endtask

  task automatic test_flush_wrap();
    bit got, dbl, seen; logic [63:0] a; int lat, f [4], gseen;
    logic [63:0] base [4];
    apply_reset();
    base[0] = 64'h0000_0011_0020_0000; base[1] = 64'h0000_0022_0040_0000;
    base[2] = 64'h0000_0033_0060_0000; base[3] = 64'h0000_0044_0080_0000;
    set_addrs(base[0], base[1], base[2], base[3]);
    set_status(4'b1111);
    for (int k = 0; k < 4; k++) f[k] = free_cnt[k];
    // Page 1: one grant, flush, free after the completion.
    request_chunk(8, 10, got, a, lat, dbl);
    n_checks++; if (got !== 1'b1 || a !== base[0]) begin n_fail++; $display("FAIL flush_p1_addr: got %b/%h expected 1/%h", got, a, base[0]); end
    pulse_flush();
    pulse_done();
    wait_free(0, f[0], 10, seen);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL flush_p1_free: got seen=%b expected 1", seen); end
    set_status(4'b1110);
    // Page 2: flush at offset 0 is ignored.
    repeat (3) tick();
    pulse_flush();
    repeat (5) tick();
    n_checks++; if (free_cnt[1] - f[1] !== 0 || bus.cur_page !== 2'd1) begin
      n_fail++; $display("FAIL flush_zero_ignored: got pulses=%0d page=%0d expected 0/1", free_cnt[1] - f[1], bus.cur_page);
    end
    request_chunk(8, 10, got, a, lat, dbl);
    n_checks++; if (got !== 1'b1 || a !== base[1]) begin n_fail++; $display("FAIL flush_p2_addr: got %b/%h expected 1/%h", got, a, base[1]); end
    // Flush and request in the same cycle: flush wins, request moves on.
    bus.chunk_qwords = 10'd8;
    bus.chunk_req    = 1'b1;
    bus.page_flush   = 1'b1;
    tick();
    bus.page_flush   = 1'b0;
    gseen = (bus.chunk_gnt === 1'b1) ? 1 : 0;
    tick();
    if (bus.chunk_gnt === 1'b1) gseen++;
    n_checks++; if (gseen !== 0) begin n_fail++; $display("FAIL flush_priority: got %0d grants expected 0", gseen); end
    pulse_done();
    got = 1'b0; a = '0;
    for (int c = 0; c < 12 && !got; c++) begin
      tick();
      if (bus.chunk_gnt === 1'b1) begin got = 1'b1; a = bus.chunk_addr; end
    end
    tick();
    bus.chunk_req = 1'b0;
    n_checks++; if (got !== 1'b1 || a !== base[2]) begin n_fail++; $display("FAIL flush_p3_addr: got %b/%h expected 1/%h", got, a, base[2]); end
    n_checks++; if (free_cnt[1] - f[1] !== 1) begin n_fail++; $display("FAIL flush_p2_free: got %0d expected 1", free_cnt[1] - f[1]); end
    // Page 3 holds one outstanding chunk.
    pulse_flush();
    pulse_done();
    wait_free(2, f[2], 10, seen);
    // Page 4: free must wait for the completion.
    request_chunk(8, 10, got, a, lat, dbl);
    n_checks++; if (got !== 1'b1 || a !== base[3]) begin n_fail++; $display("FAIL flush_p4_addr: got %b/%h expected 1/%h", got, a, base[3]); end
    pulse_flush();
    repeat (4) tick();
    n_checks++; if (free_cnt[3] - f[3] !== 0) begin n_fail++; $display("FAIL flush_p4_early: got %0d expected 0", free_cnt[3] - f[3]); end
    pulse_done();
    wait_free(3, f[3], 10, seen);
    repeat (3) tick();
    n_checks++; if (free_cnt[3] - f[3] !== 1) begin n_fail++; $display("FAIL flush_p4_free: got %0d expected 1", free_cnt[3] - f[3]); end
    n_checks++; if (bus.cur_page !== 2'd0) begin n_fail++; $display("FAIL flush_wrap_page: got %0d expected 0", bus.cur_page); end
    request_chunk(8, 8, got, a, lat, dbl);
    n_checks++; if (got !== 1'b0) begin n_fail++; $display("FAIL wrap_wait_status: got grant=%b expected 0", got); end
    set_status(4'b1111);
    request_chunk(8, 10, got, a, lat, dbl);
    n_checks++; if (got !== 1'b1 || a !== base[0]) begin n_fail++; $display("FAIL wrap_regrant: got %b/%h expected 1/%h", got, a, base[0]); end
    pulse_done();
  endtask

  // Reference model: page index, byte offset and pending-write count tracked
  // as plain integers; each request is predicted from those alone.
  task automatic test_random();
    bit got, dbl; logic [63:0] a, exp_a; int lat;
    logic [63:0] rbase [4];
    int mpage, moff, mpend, qw, bytes, r;
    int mfree [4], f0 [4];
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      rbase[k] = {32'($urandom_range(1, 255)), $urandom() & 32'hFFE0_0000};
      f0[k] = free_cnt[k];
      mfree[k] = 0;
    end
    set_addrs(rbase[0], rbase[1], rbase[2], rbase[3]);
    set_status(4'b1111);
    mpage = 0; moff = 0; mpend = 0;
    for (int op = 0; op < 150; op++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        pulse_flush();
        if (moff > 0) begin
          repeat (mpend) pulse_done();
          mpend = 0;
          mfree[mpage]++;
          mpage = (mpage + 1) % 4;
          moff = 0;
        end
      end else if (r < 4 && mpend > 0) begin
        pulse_done();
        mpend--;
      end else begin
        if (mpend == MAX_OUT) begin pulse_done(); mpend--; end
        qw = $urandom_range(1, 512);
        bytes = qw * 8;
        if (moff + bytes > PAGE_BYTES) begin
          repeat (mpend) pulse_done();
          mpend = 0;
          mfree[mpage]++;
          mpage = (mpage + 1) % 4;
          moff = 0;
        end
        exp_a = rbase[mpage] + 64'(moff);
        request_chunk(qw, 20, got, a, lat, dbl);
        n_checks++;
        if (got !== 1'b1 || a !== exp_a || dbl !== 1'b0) begin
          n_fail++; $display("FAIL rand_grant op%0d: got %b/%h dbl=%b expected 1/%h dbl=0", op, got, a, dbl, exp_a);
        end
        moff += bytes;
        mpend++;
      end
    end
    repeat (mpend) pulse_done();
    repeat (6) tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (free_cnt[k] - f0[k] !== mfree[k]) begin
        n_fail++; $display("FAIL rand_free%0d: got %0d expected %0d", k + 1, free_cnt[k] - f0[k], mfree[k]);
      end
    end
    n_checks++; if (bus.cur_page !== 2'(mpage)) begin n_fail++; $display("FAIL rand_cur_page: got %0d expected %0d", bus.cur_page, mpage); end
  endtask

  task automatic test_error_reset();
    bit got, dbl; logic [63:0] a; int lat, f [4], fsum;
    apply_reset();
    set_addrs(64'h0000_0009_0000_0000, 64'h0000_000A_0000_0000, 64'h0, 64'h0);
    set_status(4'b0011);
    tick(); tick();
    n_checks++; if (bus.err_underflow !== 1'b0) begin n_fail++; $display("FAIL err_initial: got %b expected 0", bus.err_underflow); end
    pulse_done();
    n_checks++; if (bus.err_underflow !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", bus.err_underflow); end
    request_chunk(8, 10, got, a, lat, dbl);
    n_checks++; if (got !== 1'b1 || a !== 64'h0000_0009_0000_0000) begin n_fail++; $display("FAIL err_hold_zero: got %b/%h expected 1/900000000", got, a); end
    pulse_done();
    repeat (3) tick();
    n_checks++; if (bus.err_underflow !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", bus.err_underflow); end
    request_chunk(8, 10, got, a, lat, dbl);
    pulse_flush();
    tick(); tick();
    for (int k = 0; k < 4; k++) f[k] = free_cnt[k];
    reset = 1'b1;
    tick();
    n_checks++;
    if (bus.chunk_gnt !== 1'b0 || bus.chunk_addr !== 64'h0 || bus.cur_page !== 2'd0 || bus.err_underflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_drain: got gnt=%b addr=%h page=%0d err=%b expected all 0",
                         bus.chunk_gnt, bus.chunk_addr, bus.cur_page, bus.err_underflow);
    end
    reset = 1'b0;
    repeat (5) tick();
    fsum = 0;
    for (int k = 0; k < 4; k++) fsum += free_cnt[k] - f[k];
    n_checks++; if (fsum !== 0) begin n_fail++; $display("FAIL reset_no_free: got %0d pulses expected 0", fsum); end
    request_chunk(8, 10, got, a, lat, dbl);
    n_checks++; if (got !== 1'b1 || a !== 64'h0000_0009_0000_0000) begin n_fail++; $display("FAIL reset_restart: got %b/%h expected 1/900000000", got, a); end
    pulse_done();
    n_checks++; if (bus.err_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_ctr_cleared: got %b expected 0", bus.err_underflow); end
  endtask

  initial begin
    reset            = 1'b1;
    bus.chunk_req    = 1'b0;
    bus.chunk_qwords = '0;
    bus.chunk_done   = 1'b0;
    bus.page_flush   = 1'b0;
    set_status(4'b0000);
    set_addrs(64'h0, 64'h0, 64'h0, 64'h0);
    test_reset();
    test_basic_grant();
    test_page_fill();
    test_misfit();
    test_outstanding_limit();
    test_flush_wrap();
    test_random();
    test_error_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
